// File: rtl/encoder_16_to_4.sv
// 16-to-4 priority encoder (highest set bit wins) for the instruction-family vector,
// with a registered copy of the result and a sticky flag for vectors that are not one-hot.
module encoder_16_to_4 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bits,
   output logic [3:0]  number,
   output logic        valid,
   output logic        multi_hot,
   output logic [3:0]  number_q,
   output logic        valid_q,
   output logic        err_sticky
);

   logic [3:0]       grp_any;
   logic [3:0][1:0]  grp_idx;
   logic [1:0]       top_grp;
   logic [15:0]      winner_mask;

   // Two-level tree: a 4:2 priority pick inside each nibble, then a 4:2 pick across nibbles.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      grp_any = '0;
      grp_idx = '0;
      for (int g = 0; g < 4; g++) begin
         grp_any[g] = |bits[4*g +: 4];
         for (int k = 0; k < 4; k++) begin
            if (bits[4*g + k]) begin
               grp_idx[g] = 2'(k);
            end
         end
      end
   end

   always_comb begin
      top_grp = 2'd0;
      for (int g = 0; g < 4; g++) begin
         if (grp_any[g]) begin
            top_grp = 2'(g);
         end
      end
   end

   always_comb begin
      number      = {top_grp, grp_idx[top_grp]};
      valid       = |grp_any;
      winner_mask = 16'd1 << number;
      // Any bit left after removing the winner means at least two bits were set.
      multi_hot   = valid & (|(bits & ~winner_mask));
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         number_q   <= 4'd0;
         valid_q    <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         number_q   <= number;
         valid_q    <= valid;
         err_sticky <= err_sticky | multi_hot;
      end
   end

endmodule

// File: tb/tb_encoder_16_to_4.sv
// Self-checking bench for encoder_16_to_4: directed test-plan cases plus random vectors
// checked against a behavioural model (highest-index scan, popcount, register model).
module tb_encoder_16_to_4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] bits;
   logic [3:0]  number;
   logic        valid;
   logic        multi_hot;
   logic [3:0]  number_q;
   logic        valid_q;
   logic        err_sticky;

   int errors = 0;
   int checks = 0;

   // Model of the registered outputs
   logic [3:0] m_number_q;
   logic       m_valid_q;
   logic       m_err;

   always #5 clk = ~clk;

   encoder_16_to_4 dut (
      .clk        (clk),
      .rst        (rst),
      .bits       (bits),
      .number     (number),
      .valid      (valid),
      .multi_hot  (multi_hot),
      .number_q   (number_q),
      .valid_q    (valid_q),
      .err_sticky (err_sticky)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (bits=%04h rst=%0b t=%0t)",
                  tag, obs, exp, bits, rst, $time);
      end
   endtask

   function automatic int ref_index(input logic [15:0] b);
      int r = 0;
      for (int i = 0; i < 16; i++) begin
         if (b[i]) r = i;
      end
      return r;
   endfunction

   // Drive one vector, check the combinational outputs in the same cycle,
   // then check the registered outputs after the following rising edge.
   task automatic apply(input logic [15:0] b, input logic r);
      int         idx;
      logic       exp_valid;
      logic       exp_multi;
      logic [6:0] exp_addr;
      @(negedge clk);
      bits = b;
      rst  = r;
      #1;
      idx       = ref_index(b);
      exp_valid = (b != 16'h0000);
      exp_multi = ($countones(b) >= 2);
      exp_addr  = 7'(idx * 8);
      check("number",    32'(number),             32'(idx));
      check("valid",     32'(valid),              32'(exp_valid));
      check("multi_hot", 32'(multi_hot),          32'(exp_multi));
      check("addr",      32'({number, 3'b000}),   32'(exp_addr));
      if (r) begin
         m_number_q = 4'd0;
         m_valid_q  = 1'b0;
         m_err      = 1'b0;
      end else begin
         m_number_q = 4'(idx);
         m_valid_q  = exp_valid;
         m_err      = m_err | exp_multi;
      end
      @(posedge clk);
      #1;
      check("number_q",   32'(number_q),   32'(m_number_q));
      check("valid_q",    32'(valid_q),    32'(m_valid_q));
      check("err_sticky", 32'(err_sticky), 32'(m_err));
   endtask

   initial begin
      logic [15:0] rb;
      int          mode;
      bits       = 16'h0000;
      rst        = 1'b1;
      m_number_q = 4'd0;
      m_valid_q  = 1'b0;
      m_err      = 1'b0;

      // Reset state
      apply(16'h0000, 1'b1);
      apply(16'h0000, 1'b1);

      // One-hot sweep
      for (int i = 0; i < 16; i++) begin
         apply(16'h0001 << i, 1'b0);
      end

      // Zero input
      apply(16'h0000, 1'b0);

      // Priority / multi-hot
      apply(16'h0105, 1'b0);
      apply(16'hFFFF, 1'b0);
      apply(16'h0003, 1'b0);

      // Sticky error holds, then clears on reset
      for (int i = 0; i < 5; i++) begin
         apply(16'h0010, 1'b0);
      end
      apply(16'h0010, 1'b1);

      // Reset collides with a multi-hot vector
      apply(16'h0105, 1'b0);
      apply(16'h0300, 1'b1);

      // Reset released mid-stream, then decoder integration vector
      apply(16'h0040, 1'b0);
      apply(16'h0800, 1'b0);

      // Random vectors: mix of one-hot, zero, sparse and dense patterns
      for (int n = 0; n < 400; n++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       rb = 16'h0001 << $urandom_range(0, 15);
            1:       rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            2:       rb = 16'($urandom) & 16'($urandom) & 16'($urandom);
            default: rb = 16'($urandom);
         endcase
         apply(rb, ($urandom_range(0, 24) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
